letc_axi_manager: RTL
=====================

Name: letc_axi_manager

Overview:
- AXI manager (initiator) for LETC peripherals such as letc_periph_sram. It is the initiator end of the same axi_if protocol those peripherals respond to.
- Converts a simple command / write-data / read-data / completion stream interface into single-outstanding INCR bursts on axi_if.
- Used by LETC bus bridges and DMA-style engines. Also reused in benches as a synthesizable traffic source.

Parameters:
- ID, 0: value driven on awid/arid/wid; expected on bid/rid.

Ports:
- i_clk  input  1  clock; also clocks the axi_if instance
- i_rst  input  1  synchronous reset, active-high
- axi  interface  axi_if  manager side; widths IDWIDTH, AWIDTH, DWIDTH, WSTRBWIDTH, LENWIDTH from axi_pkg
- i_cmd_valid  input  1  command valid
- o_cmd_ready  output  1  command accepted when valid&ready
- i_cmd_write  input  1  1 = write burst, 0 = read burst
- i_cmd_addr  input  AWIDTH  start byte address, DWIDTH/8 aligned
- i_cmd_len  input  LENWIDTH  beats minus 1 (0..255)
- i_wdata_valid  input  1  write beat valid
- o_wdata_ready  output  1  write beat consumed
- i_wdata  input  DWIDTH  write beat data
- i_wstrb  input  WSTRBWIDTH  write beat byte strobes
- o_rdata_valid  output  1  read beat valid
- i_rdata_ready  input  1  read beat consumed
- o_rdata  output  DWIDTH  read beat data
- o_rdata_last  output  1  final read beat
- o_done_valid  output  1  burst complete
- i_done_ready  input  1  completion consumed
- o_done_resp  output  axi_pkg::resp_e  burst response
- o_proto_err  output  1  sticky protocol error (optional feature only)

Behaviour:
- FSM states: IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, DONE. One burst in flight at a time.
- Reset (sync, i_rst=1 at posedge):
  - state=IDLE.
  - awvalid, wvalid, bready, arvalid, rready, o_done_valid, o_proto_err all 0.
  - Beat counter and latched command cleared.
  - Reset mid-burst abandons the transaction; the responder is reset in the same cycle by system design.
- IDLE:
  - o_cmd_ready=1; it is 0 in every other state.
  - On handshake, latch addr/len/write. Next state is WRITE (write) or RD_ADDR (read).
  - awvalid/arvalid rise the cycle after acceptance.
- Constant fields:
  - awburst/arburst = INCR.
  - awsize/arsize = $clog2(DWIDTH/8).
  - Ids = ID.
  - awaddr/araddr/awlen/arlen come from latched registers and are stable while valid.
- WRITE:
  - AW and W proceed independently.
  - awvalid is held until awready, then stays 0 (aw_done flag).
  - Write-data pass-through: wvalid = i_wdata_valid while beats remain; o_wdata_ready = wready & beats remain.
  - wdata/wstrb pass straight through.
  - wlast=1 when beat counter == latched len.
  - Beat counter increments on each W handshake.
  - Exit to WR_RESP when aw_done and the last W beat have both handshaken, including the same cycle.
  - W may complete before AW.
- WR_RESP: bready=1. On B handshake, capture bresp and go to DONE.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA:
  - Read pass-through: o_rdata_valid = rvalid, rready = i_rdata_ready, o_rdata = rdata.
  - o_rdata_last = (beat counter == latched len). It is generated locally; rlast is not used for this.
  - Resp is accumulated per beat as the numeric max (OKAY<EXOKAY<SLVERR<DECERR).
  - On the final beat handshake, go to DONE.
- DONE:
  - o_done_valid=1, o_done_resp = captured resp. Both are held until i_done_ready.
  - Then IDLE. The next command is accepted one cycle later.
- Minimum latencies, assuming the responder is always ready:
  - Read, len=0: cmd accept N; arvalid N+1; rdata earliest N+2; o_done_valid the cycle after the last beat.
  - Write, len=0: B earliest N+2.
- Boundaries:
  - len=0 means a single beat with wlast on the first beat.
  - len=255 means 256 beats; the counter is LENWIDTH bits and must not wrap before compare.
  - Input stall (i_wdata_valid=0) or output backpressure (i_rdata_ready=0) simply holds; no beats are lost.
  - 4KB crossing is the caller's responsibility and is not checked.

Optional Feature:
- Macro: LETC_AXI_MANAGER_PROTOCOL_CHECK_EN.
- Enabled, a protocol error is any of:
  - bid or rid != ID on handshake.
  - rlast mismatch with the locally computed last beat.
  - bvalid/rvalid while in IDLE.
- Enabled, effect of an error:
  - o_proto_err is set (sticky until reset).
  - That burst's o_done_resp is forced to SLVERR.
- Disabled: ids and rlast are ignored; o_proto_err is tied 0.

Test Plan:
- Write, len=0, addr 0x40, data 0xDEADBEEF, wstrb 0xF, responder always ready -> awaddr=0x40, awlen=0, wlast=1 on the beat, o_done_resp=OKAY with o_done_valid no earlier than cycle N+3.
- Write, len=3, data 1..4; W offered before awready (awready delayed 5 cycles) -> 4 W handshakes, wlast only on beat 4, single B, o_done_valid after bvalid.
- Read, len=7 from 0x100; i_rdata_ready toggles 1/0 -> 8 beats delivered in order, o_rdata_last only on beat 8, o_cmd_ready=0 until done is consumed.
- Read, len=1 with rresp SLVERR on beat 1 and OKAY on beat 2 -> o_done_resp=SLVERR. Then a DECERR write response -> DECERR.
- Assert i_rst in the middle of the RD_DATA beat 3 of len=7 -> the next cycle has all valids 0, state IDLE, o_cmd_ready=1, and a new command completes normally.
- With LETC_AXI_MANAGER_PROTOCOL_CHECK_EN, responder returns rid=ID+1 -> o_proto_err=1 (sticky) and o_done_resp=SLVERR. Without the macro -> OKAY and o_proto_err=0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI widths and enumerations for LETC managers and peripherals.
package axi_pkg;

    localparam int IDWIDTH    = 4;
    localparam int AWIDTH     = 32;
    localparam int DWIDTH     = 32;
    localparam int WSTRBWIDTH = DWIDTH / 8;
    localparam int LENWIDTH   = 8;

    // Encoding order doubles as severity order for response accumulation.
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

endpackage

// File: rtl/axi_if.sv
// AXI channel bundle shared by LETC managers (initiators) and subordinates.
interface axi_if (
    input logic i_clk
);

    logic [axi_pkg::IDWIDTH-1:0]    awid;
    logic [axi_pkg::AWIDTH-1:0]     awaddr;
    logic [axi_pkg::LENWIDTH-1:0]   awlen;
    logic [2:0]                     awsize;
    axi_pkg::burst_e                awburst;
    logic                           awvalid;
    logic                           awready;

    logic [axi_pkg::IDWIDTH-1:0]    wid;
    logic [axi_pkg::DWIDTH-1:0]     wdata;
    logic [axi_pkg::WSTRBWIDTH-1:0] wstrb;
    logic                           wlast;
    logic                           wvalid;
    logic                           wready;

    logic [axi_pkg::IDWIDTH-1:0]    bid;
    axi_pkg::resp_e                 bresp;
    logic                           bvalid;
    logic                           bready;

    logic [axi_pkg::IDWIDTH-1:0]    arid;
    logic [axi_pkg::AWIDTH-1:0]     araddr;
    logic [axi_pkg::LENWIDTH-1:0]   arlen;
    logic [2:0]                     arsize;
    axi_pkg::burst_e                arburst;
    logic                           arvalid;
    logic                           arready;

    logic [axi_pkg::IDWIDTH-1:0]    rid;
    logic [axi_pkg::DWIDTH-1:0]     rdata;
    axi_pkg::resp_e                 rresp;
    logic                           rlast;
    logic                           rvalid;
    logic                           rready;

    modport manager (
        input  i_clk,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport subordinate (
        input  i_clk,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/letc_axi_manager.sv
// Command/data stream to single-outstanding AXI INCR burst manager.
// Optional response checking: define LETC_AXI_MANAGER_PROTOCOL_CHECK_EN.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | ready for a command
// WRITE   | AW and W channels in flight independently
// WR_RESP | waiting for the B response
// RD_ADDR | presenting AR
// RD_DATA | passing R beats through to the read stream
// DONE    | presenting completion until consumed
module letc_axi_manager #(
    parameter logic [axi_pkg::IDWIDTH-1:0] ID = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    axi_if.manager                         axi,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_write,
    input  logic [axi_pkg::AWIDTH-1:0]     i_cmd_addr,
    input  logic [axi_pkg::LENWIDTH-1:0]   i_cmd_len,
    input  logic                           i_wdata_valid,
    output logic                           o_wdata_ready,
    input  logic [axi_pkg::DWIDTH-1:0]     i_wdata,
    input  logic [axi_pkg::WSTRBWIDTH-1:0] i_wstrb,
    output logic                           o_rdata_valid,
    input  logic                           i_rdata_ready,
    output logic [axi_pkg::DWIDTH-1:0]     o_rdata,
    output logic                           o_rdata_last,
    output logic                           o_done_valid,
    input  logic                           i_done_ready,
    output axi_pkg::resp_e                 o_done_resp,
    output logic                           o_proto_err
);

    import axi_pkg::*;

    localparam logic [2:0] SIZE = 3'($clog2(DWIDTH / 8));

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [AWIDTH-1:0]     addr_q;
    logic [LENWIDTH-1:0]   len_q;
    logic [LENWIDTH-1:0]   cnt_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  burst_err_q;
    logic                  proto_err_q;
    resp_e                 resp_q;

    logic                  beat_last;
    logic                  cmd_hs;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  proto_err_now;
    logic                  unused_ok;

    // Counter is compared before increment, so len=255 never needs a wrap.
    assign beat_last = (cnt_q == len_q);

    assign cmd_hs = (state_q == IDLE)    && i_cmd_valid;
    assign aw_hs  = (state_q == WRITE)   && !aw_done_q && axi.awready;
    assign w_hs   = (state_q == WRITE)   && !w_done_q && i_wdata_valid && axi.wready;
    assign b_hs   = (state_q == WR_RESP) && axi.bvalid;
    assign ar_hs  = (state_q == RD_ADDR) && axi.arready;
    assign r_hs   = (state_q == RD_DATA) && axi.rvalid && i_rdata_ready;

    assign axi.awid    = ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = SIZE;
    assign axi.awburst = INCR;
    assign axi.wid     = ID;
    assign axi.wdata   = i_wdata;
    assign axi.wstrb   = i_wstrb;
    assign axi.wlast   = beat_last;
    assign axi.arid    = ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = SIZE;
    assign axi.arburst = INCR;

    assign o_rdata      = axi.rdata;
    assign o_rdata_last = beat_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_cmd_ready   = 1'b0;
        o_wdata_ready = 1'b0;
        o_rdata_valid = 1'b0;
        o_done_valid  = 1'b0;
        axi.awvalid   = 1'b0;
        axi.wvalid    = 1'b0;
        axi.bready    = 1'b0;
        axi.arvalid   = 1'b0;
        axi.rready    = 1'b0;
        case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    state_d = i_cmd_write ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
                axi.awvalid   = !aw_done_q;
                axi.wvalid    = i_wdata_valid && !w_done_q;
                o_wdata_ready = axi.wready && !w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && beat_last))) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                axi.bready = 1'b1;
                if (b_hs) begin
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (ar_hs) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                o_rdata_valid = axi.rvalid;
                axi.rready    = i_rdata_ready;
                if (r_hs && beat_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done_valid = 1'b1;
                if (i_done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            burst_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            resp_q      <= OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q      <= i_cmd_addr;
                len_q       <= i_cmd_len;
                cnt_q       <= '0;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
                burst_err_q <= 1'b0;
                resp_q      <= OKAY;
            end
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                cnt_q <= cnt_q + LENWIDTH'(1);
                if (beat_last) begin
                    w_done_q <= 1'b1;
                end
            end
            if (b_hs) begin
                resp_q <= axi.bresp;
            end
            // Worst response over all read beats wins.
            if (r_hs) begin
                cnt_q <= cnt_q + LENWIDTH'(1);
                if (axi.rresp > resp_q) begin
                    resp_q <= axi.rresp;
                end
            end
            if (proto_err_now) begin
                proto_err_q <= 1'b1;
                burst_err_q <= 1'b1;
            end
        end
    end

`ifdef LETC_AXI_MANAGER_PROTOCOL_CHECK_EN
    assign proto_err_now = (b_hs && (axi.bid != ID))
                        || (r_hs && ((axi.rid != ID) || (axi.rlast != beat_last)))
                        || ((state_q == IDLE) && (axi.bvalid || axi.rvalid));
    assign o_done_resp   = burst_err_q ? SLVERR : resp_q;
    assign o_proto_err   = proto_err_q;
    assign unused_ok     = axi.i_clk;
`else
    assign proto_err_now = 1'b0;
    assign o_done_resp   = resp_q;
    assign o_proto_err   = 1'b0;
    assign unused_ok     = ^{axi.i_clk, axi.bid, axi.rid, axi.rlast, burst_err_q, proto_err_q};
`endif

endmodule
